serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/serial_adder_fa_bit.sv | 21 ++
 rtl/serial_adder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   state_t   - FSM state encoding (IDLE, RUN, DONE)
//   MAX_WIDTH - largest supported operand width
//   cnt_w()   - bit counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 32;

    // The counter must index bits 0..width-1; a 1-bit operand still needs
    // a 1-bit counter so the declaration never collapses to zero width.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Purely combinational 1-bit full adder.
// Ports:
//   i_a, i_b  - operand bits
//   i_cin     - carry in
//   o_sum     - sum bit
//   o_cout    - carry out
// -----------------------------------------------------------------------------
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial ripple adder: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, using a single full-adder cell and a registered carry.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. valid never depends on ready. Operands offered
// while in_ready=0 are ignored, not queued. Once out_valid rises, sum/cout
// (and ovf) hold until the result transfer completes.
//
// Parameters:
//   WIDTH        - operand/result width, 1..MAX_WIDTH
// Ports:
//   clk          - rising-edge clock
//   rst_n        - synchronous active-low reset
//   in_valid     - operand set a/b/cin valid
//   in_ready     - block can accept operands (IDLE only)
//   a, b, cin    - operands and carry-in
//   out_valid    - result valid (DONE only)
//   out_ready    - consumer accepts result
//   sum, cout    - result bits and carry out of bit WIDTH-1
//   ovf          - signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//   o_dbg_state  - current FSM state, for observation
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf port and the flop
// that captures the carry into the MSB.
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_carry_msb;
`endif

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    fa_bit u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == LAST_BIT);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
    // Written as shift/OR so it also holds for WIDTH=1.
    assign w_sum_next = (r_sum >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_carry_msb <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_fa_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    if (w_last) begin
                        r_state <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry feeding the MSB cell, needed for signed overflow.
                        r_carry_msb <= r_carry;
`endif
                    end else begin
                        // Counter stops at LAST_BIT; it never wraps.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state only; in_ready is also held low
    // while reset is asserted.
    assign in_ready    = rst_n && (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign sum         = r_sum;
    assign cout        = r_carry;
    assign o_dbg_state = r_state;

`ifdef SERIAL_ADDER_OVF_EN
    // Only meaningful with out_valid; forced low elsewhere so it reads 0
    // after reset and between results.
    assign ovf = (r_state == DONE) && (r_carry_msb ^ r_carry);
`else
    // No overflow output in this build.
`endif

endmodule
